// File: rtl/store.sv
// RV32I store unit: computes the effective address, lane-aligns SB/SH/SW data and drives a req/ack write port.
// Latency: 2 cycles enable->done for an ack in cycle 1, 1 cycle for rejected stores; RMW build adds a read phase.
// Backpressure: the request holds until memory_write_ack; busy blocks new enables. STORE_RMW_EN selects read-merge-write.
module store (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [31:0] immediate12,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] memory_write_address,
    output logic [31:0] memory_write_value,
    output logic [3:0]  memory_write_strobe,
    output logic        memory_write_request,
    input  logic        memory_write_ack,
    output logic [31:0] memory_read_address,
    output logic        memory_read_request,
    input  logic [31:0] memory_read_value,
    input  logic        memory_read_valid
);

    localparam logic [2:0] SB = 3'h0;
    localparam logic [2:0] SH = 3'h1;
    localparam logic [2:0] SW = 3'h2;

    localparam logic [1:0] IDLE  = 2'd0;
`ifdef STORE_RMW_EN
    localparam logic [1:0] READ  = 2'd1;
`endif
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  stb_q;
    logic        err_q;

    logic [31:0] ea;
    logic [31:0] lane_dat;
    logic [3:0]  lane_stb;
    logic        reject;
    logic [1:0]  accept_state;

    assign ea = operand1 + immediate12;

    always_comb begin
        lane_dat = 32'h0;
        lane_stb = 4'h0;
        reject   = 1'b0;
        case (funct3)
            SB: begin
                lane_dat = {4{operand2[7:0]}};
                lane_stb = 4'b0001 << ea[1:0];
            end
            SH: begin
                lane_dat = {2{operand2[15:0]}};
                lane_stb = 4'b0011 << {ea[1], 1'b0};
                reject   = ea[0];
            end
            SW: begin
                lane_dat = operand2;
                lane_stb = 4'hF;
                reject   = (ea[1:0] != 2'b00);
            end
            default: reject = 1'b1;
        endcase
    end

`ifdef STORE_RMW_EN
    logic [31:0] merged;

    // Lanes outside the store keep the word just read back from memory.
    always_comb begin
        merged = 32'h0;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = stb_q[i] ? data_q[8*i +: 8] : memory_read_value[8*i +: 8];
    end

    assign accept_state         = reject ? RESP : ((funct3 == SW) ? WRITE : READ);
    assign memory_write_strobe  = 4'hF;
    assign memory_read_request  = (state == READ);
    assign memory_read_address  = addr_q;
`else
    logic unused_read_port;

    assign unused_read_port     = ^{memory_read_value, memory_read_valid};
    assign accept_state         = reject ? RESP : WRITE;
    assign memory_write_strobe  = stb_q;
    assign memory_read_request  = 1'b0;
    assign memory_read_address  = 32'h0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= 32'h0;
            data_q <= 32'h0;
            stb_q  <= 4'h0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    addr_q <= {ea[31:2], 2'b00};
                    data_q <= lane_dat;
                    stb_q  <= lane_stb;
                    err_q  <= reject;
                    state  <= accept_state;
                end
`ifdef STORE_RMW_EN
                READ: if (memory_read_valid) begin
                    data_q <= merged;
                    state  <= WRITE;
                end
`endif
                WRITE: if (memory_write_ack) state <= RESP;
                RESP: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                 = (state != IDLE);
    assign done                 = (state == RESP);
    assign error                = done & err_q;
    assign memory_write_request = (state == WRITE);
    assign memory_write_address = addr_q;
    assign memory_write_value   = data_q;

endmodule

// File: tb/tb_store.sv
// Self-checking bench for store: directed cases plus randomized stores against a byte-lane reference model.
module tb_store;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] operand1 = 32'h0, operand2 = 32'h0, immediate12 = 32'h0;
    logic        busy, done, error;
    logic [31:0] memory_write_address, memory_write_value;
    logic [3:0]  memory_write_strobe;
    logic        memory_write_request;
    logic        memory_write_ack = 1'b0;
    logic [31:0] memory_read_address;
    logic        memory_read_request;
    logic [31:0] memory_read_value = 32'h0;
    logic        memory_read_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef STORE_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    store dut (
        .clock(clock), .reset(reset), .enable(enable), .funct3(funct3),
        .operand1(operand1), .operand2(operand2), .immediate12(immediate12),
        .busy(busy), .done(done), .error(error),
        .memory_write_address(memory_write_address), .memory_write_value(memory_write_value),
        .memory_write_strobe(memory_write_strobe), .memory_write_request(memory_write_request),
        .memory_write_ack(memory_write_ack),
        .memory_read_address(memory_read_address), .memory_read_request(memory_read_request),
        .memory_read_value(memory_read_value), .memory_read_valid(memory_read_valid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: place each byte of the store by its address within the word.
    task automatic model(input logic [2:0] f3, input logic [31:0] op1, op2, imm, rd_word,
                         output logic [31:0] addr, value, output logic [3:0] stb,
                         output bit err, output bit needs_read);
        logic [31:0] e;
        logic [3:0]  mask;
        e     = op1 + imm;
        addr  = e - (e % 4);
        mask  = 4'h0;
        err   = 1'b0;
        value = 32'h0;
        for (int i = 0; i < 4; i++) begin
            case (f3)
                3'h0: begin value[8*i +: 8] = op2[7:0];             mask[i] = (i == e % 4); end
                3'h1: begin value[8*i +: 8] = op2[8*(i%2) +: 8];    mask[i] = (i / 2 == (e % 4) / 2); end
                3'h2: begin value[8*i +: 8] = op2[8*i +: 8];        mask[i] = 1'b1; end
                default: ;
            endcase
        end
        if (f3 > 3'h2) err = 1'b1;
        if (f3 == 3'h1 && e % 2 != 0) err = 1'b1;
        if (f3 == 3'h2 && e % 4 != 0) err = 1'b1;
        needs_read = RMW && (f3 != 3'h2);
        stb = mask;
        if (RMW) begin
            for (int i = 0; i < 4; i++)
                if (!mask[i]) value[8*i +: 8] = rd_word[8*i +: 8];
            stb = 4'hF;
        end
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] op1, op2, imm,
                             input int ack_dly, input int rd_dly, input bit noise,
                             input logic [31:0] rd_word);
        logic [31:0] ea_addr, ev;
        logic [3:0]  es;
        bit          ee, nr;
        model(f3, op1, op2, imm, rd_word, ea_addr, ev, es, ee, nr);
        check("idle_busy", {31'h0, busy}, 32'h0);
        funct3 = f3; operand1 = op1; operand2 = op2; immediate12 = imm; enable = 1'b1;
        tick();
        enable = noise;
        funct3 = 3'($urandom); operand1 = $urandom; operand2 = $urandom; immediate12 = $urandom;
        if (ee) begin
            check("rej_done", {31'h0, done}, 32'h1);
            check("rej_error", {31'h0, error}, 32'h1);
            check("rej_wreq", {31'h0, memory_write_request}, 32'h0);
            check("rej_rreq", {31'h0, memory_read_request}, 32'h0);
            tick();
        end else begin
            if (nr) begin
                for (int k = 1; k <= rd_dly; k++) begin
                    check("rd_req", {31'h0, memory_read_request}, 32'h1);
                    check("rd_addr", memory_read_address, ea_addr);
                    check("rd_wreq", {31'h0, memory_write_request}, 32'h0);
                    if (k == rd_dly) begin
                        memory_read_value = rd_word;
                        memory_read_valid = 1'b1;
                    end
                    tick();
                end
                memory_read_valid = 1'b0;
                memory_read_value = $urandom;
            end
            for (int k = 0; k <= ack_dly; k++) begin
                check("wr_req", {31'h0, memory_write_request}, 32'h1);
                check("wr_addr", memory_write_address, ea_addr);
                check("wr_value", memory_write_value, ev);
                check("wr_strobe", {28'h0, memory_write_strobe}, {28'h0, es});
                check("wr_done", {31'h0, done}, 32'h0);
                if (k == ack_dly) memory_write_ack = 1'b1;
                tick();
            end
            memory_write_ack = 1'b0;
            check("resp_done", {31'h0, done}, 32'h1);
            check("resp_error", {31'h0, error}, 32'h0);
            check("resp_wreq", {31'h0, memory_write_request}, 32'h0);
            tick();
        end
        enable = 1'b0;
        check("end_busy", {31'h0, busy}, 32'h0);
        check("end_done", {31'h0, done}, 32'h0);
        check("end_error", {31'h0, error}, 32'h0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_wreq", {31'h0, memory_write_request}, 32'h0);
        check("rst_addr", memory_write_address, 32'h0);
        check("rst_value", memory_write_value, 32'h0);
        check("rst_strobe", {28'h0, memory_write_strobe}, RMW ? 32'hF : 32'h0);
        check("rst_rreq", {31'h0, memory_read_request}, 32'h0);
        reset = 1'b0;
        tick();

        // Ack with nothing pending must not start anything.
        memory_write_ack = 1'b1;
        tick();
        memory_write_ack = 1'b0;
        check("stray_ack_busy", {31'h0, busy}, 32'h0);
        check("stray_ack_done", {31'h0, done}, 32'h0);

        run_store(3'h0, 32'h0000_1000, 32'h1234_56AB, 32'd3, 0, 1, 1'b0, 32'h5566_7788);
        if (!RMW) begin
            check("sb_tp_value", memory_write_value, 32'hABAB_ABAB);
            check("sb_tp_strobe", {28'h0, memory_write_strobe}, 32'h8);
        end
        run_store(3'h2, 32'h0000_2000, 32'hCAFE_F00D, 32'h0, 3, 1, 1'b1, 32'h0);
        run_store(3'h1, 32'h0000_1001, 32'h0000_BEEF, 32'h0, 0, 1, 1'b0, 32'h0);
        run_store(3'h2, 32'h0000_1002, 32'h0000_BEEF, 32'h0, 0, 1, 1'b1, 32'h0);
        run_store(3'h4, 32'h0000_1000, 32'h0000_BEEF, 32'h0, 0, 1, 1'b0, 32'h0);
        run_store(3'h0, 32'h0000_0002, 32'h0000_0077, 32'hFFFF_FFFC, 1, 2, 1'b0, 32'hDEAD_BEEF);
        check("neg_imm_addr", memory_write_address, 32'hFFFF_FFFC);
        if (!RMW) check("neg_imm_strobe", {28'h0, memory_write_strobe}, 32'h4);
        run_store(3'h1, 32'h0000_3002, 32'h0000_BEEF, 32'h0, 0, 2, 1'b0, 32'h1122_3344);
        if (RMW) check("rmw_sh_value", memory_write_value, 32'hBEEF_3344);

        // Reset in cycle 2 of a pending SW abandons it silently.
        funct3 = 3'h2; operand1 = 32'h0000_2000; immediate12 = 32'h0; operand2 = 32'h1111_2222;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("pre_rst_wreq", {31'h0, memory_write_request}, 32'h1);
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_wreq", {31'h0, memory_write_request}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst_done", {31'h0, done}, 32'h0);
        run_store(3'h2, 32'h0000_4000, 32'h3333_4444, 32'h4, 1, 1, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            logic [11:0] r;
            r = 12'($urandom);
            run_store(3'($urandom_range(0, 4)), $urandom, $urandom, {{20{r[11]}}, r},
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                      1'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
